id_ex_issue: RTL and testbench

//  ID/EX pipeline register and operand-issue stage of the 5-stage PCPU; directly feeds the ALU
//  (aluop, src0, src1, shamt). Latches decoded ID fields each cycle and forwards results from
//  the EX/MEM and MEM/WB stages. Detects the load-use hazard, stalls IF/ID and inserts a bubble.

---
 rtl/id_ex_issue_if.sv | 56 +++++
 rtl/id_ex_issue.sv | 124 ++++++++++++
 tb/tb_id_ex_issue.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_issue_if.sv
// Bundle between the ID stage, the forwarding sources and the EX-stage operand outputs.
// The "slave" side is the issue stage itself.
interface id_ex_issue_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          id_valid_i;
  logic [4:0]    id_aluop_i;
  logic [RW-1:0] id_rs_addr_i;
  logic [DW-1:0] id_rs_data_i;
  logic [RW-1:0] id_rt_addr_i;
  logic [DW-1:0] id_rt_data_i;
  logic [DW-1:0] id_imm_i;
  logic          id_use_imm_i;
  logic [4:0]    id_shamt_i;
  logic [RW-1:0] id_wb_addr_i;
  logic          id_wb_we_i;
  logic          id_mem_rd_i;
  logic          id_mem_wr_i;
  logic          flush_i;
  logic [RW-1:0] mem_wb_addr_i;
  logic          mem_we_i;
  logic [DW-1:0] mem_data_i;
  logic [RW-1:0] wb_addr_i;
  logic          wb_we_i;
  logic [DW-1:0] wb_data_i;
  logic          stall_o;
  logic          ex_valid_o;
  logic [4:0]    ex_aluop_o;
  logic [4:0]    ex_shamt_o;
  logic [DW-1:0] ex_src0_o;
  logic [DW-1:0] ex_src1_o;
  logic [DW-1:0] ex_store_data_o;
  logic [RW-1:0] ex_wb_addr_o;
  logic          ex_wb_we_o;
  logic          ex_mem_rd_o;
  logic          ex_mem_wr_o;

  modport master (
    output id_valid_i, id_aluop_i, id_rs_addr_i, id_rs_data_i, id_rt_addr_i, id_rt_data_i,
           id_imm_i, id_use_imm_i, id_shamt_i, id_wb_addr_i, id_wb_we_i, id_mem_rd_i,
           id_mem_wr_i, flush_i, mem_wb_addr_i, mem_we_i, mem_data_i, wb_addr_i, wb_we_i,
           wb_data_i,
    input  stall_o, ex_valid_o, ex_aluop_o, ex_shamt_o, ex_src0_o, ex_src1_o,
           ex_store_data_o, ex_wb_addr_o, ex_wb_we_o, ex_mem_rd_o, ex_mem_wr_o
  );

  modport slave (
    input  id_valid_i, id_aluop_i, id_rs_addr_i, id_rs_data_i, id_rt_addr_i, id_rt_data_i,
           id_imm_i, id_use_imm_i, id_shamt_i, id_wb_addr_i, id_wb_we_i, id_mem_rd_i,
           id_mem_wr_i, flush_i, mem_wb_addr_i, mem_we_i, mem_data_i, wb_addr_i, wb_we_i,
           wb_data_i,
    output stall_o, ex_valid_o, ex_aluop_o, ex_shamt_o, ex_src0_o, ex_src1_o,
           ex_store_data_o, ex_wb_addr_o, ex_wb_we_o, ex_mem_rd_o, ex_mem_wr_o
  );
endinterface

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use stall
// detection and bubble insertion on stall or flush.
module id_ex_issue #(
  parameter int unsigned DW           = 32,
  parameter int unsigned RW           = 5,
  parameter logic [4:0]  BUBBLE_ALUOP = 5'h1F
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_issue_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    aluop;
    logic [RW-1:0] rs_addr;
    logic [DW-1:0] rs_data;
    logic [RW-1:0] rt_addr;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [4:0]    shamt;
    logic [RW-1:0] wb_addr;
    logic          wb_we;
    logic          mem_rd;
    logic          mem_wr;
  } ex_regs_t;

  function automatic ex_regs_t make_bubble();
    ex_regs_t b;
    b       = '0;
    b.aluop = BUBBLE_ALUOP;
    return b;
  endfunction

  localparam ex_regs_t BubbleRegs = make_bubble();

  ex_regs_t ex_q, ex_d;
  logic     rs_hit, rt_hit, haz;

  // Load-use hazard against the instruction currently in EX.
  always_comb begin
    rs_hit = (ex_q.wb_addr == bus.id_rs_addr_i);
    rt_hit = (ex_q.wb_addr == bus.id_rt_addr_i) && (!bus.id_use_imm_i || bus.id_mem_wr_i);
    haz    = ex_q.valid && ex_q.mem_rd && ex_q.wb_we && (ex_q.wb_addr != '0) &&
             bus.id_valid_i && (rs_hit || rt_hit);
  end

  assign bus.stall_o = haz && !bus.flush_i;

  always_comb begin
    ex_d = BubbleRegs;
    if (!bus.flush_i && !haz && bus.id_valid_i) begin
      ex_d.valid   = 1'b1;
      ex_d.aluop   = bus.id_aluop_i;
      ex_d.rs_addr = bus.id_rs_addr_i;
      ex_d.rs_data = bus.id_rs_data_i;
      ex_d.rt_addr = bus.id_rt_addr_i;
      ex_d.rt_data = bus.id_rt_data_i;
      ex_d.imm     = bus.id_imm_i;
      ex_d.use_imm = bus.id_use_imm_i;
      ex_d.shamt   = bus.id_shamt_i;
      ex_d.wb_addr = bus.id_wb_addr_i;
      ex_d.wb_we   = bus.id_wb_we_i;
      ex_d.mem_rd  = bus.id_mem_rd_i;
      ex_d.mem_wr  = bus.id_mem_wr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= BubbleRegs;
    end else begin
      ex_q <= ex_d;
    end
  end

  // MEM/WB match doubles as the bypass for the same-cycle register-file write.
  function automatic logic [DW-1:0] forward(
    input logic          valid,
    input logic [RW-1:0] addr,
    input logic [DW-1:0] reg_val,
    input logic          mem_we,
    input logic [RW-1:0] mem_addr,
    input logic [DW-1:0] mem_data,
    input logic          wb_we,
    input logic [RW-1:0] wb_addr,
    input logic [DW-1:0] wb_data
  );
    if (valid && mem_we && (mem_addr != '0) && (mem_addr == addr)) begin
      return mem_data;
    end else if (valid && wb_we && (wb_addr != '0) && (wb_addr == addr)) begin
      return wb_data;
    end
    return reg_val;
  endfunction

  logic [DW-1:0] fwd_rs, fwd_rt;

  always_comb begin
    fwd_rs = forward(ex_q.valid, ex_q.rs_addr, ex_q.rs_data,
                     bus.mem_we_i, bus.mem_wb_addr_i, bus.mem_data_i,
                     bus.wb_we_i, bus.wb_addr_i, bus.wb_data_i);
    fwd_rt = forward(ex_q.valid, ex_q.rt_addr, ex_q.rt_data,
                     bus.mem_we_i, bus.mem_wb_addr_i, bus.mem_data_i,
                     bus.wb_we_i, bus.wb_addr_i, bus.wb_data_i);
  end

  assign bus.ex_valid_o      = ex_q.valid;
  assign bus.ex_aluop_o      = ex_q.aluop;
  assign bus.ex_shamt_o      = ex_q.shamt;
  assign bus.ex_src0_o       = fwd_rs;
  assign bus.ex_src1_o       = ex_q.use_imm ? ex_q.imm : fwd_rt;
  assign bus.ex_store_data_o = fwd_rt;
  assign bus.ex_wb_addr_o    = ex_q.wb_addr;
  assign bus.ex_wb_we_o      = ex_q.wb_we;
  assign bus.ex_mem_rd_o     = ex_q.mem_rd;
  assign bus.ex_mem_wr_o     = ex_q.mem_wr;

  // A stall always puts a bubble into EX, so it can never last two cycles.
  stall_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    bus.stall_o |=> !bus.stall_o);

endmodule

// File: tb/tb_id_ex_issue.sv
// Vector table with a scoreboard queue for the ID/EX issue stage, plus a reset-mid-stall sequence.
module tb_id_ex_issue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_issue_if #(.DW(32), .RW(5)) bus ();

  id_ex_issue #(.DW(32), .RW(5), .BUBBLE_ALUOP(5'h1F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic iv; logic [4:0] op; logic [4:0] rs; logic [31:0] rsd; logic [4:0] rt;
    logic [31:0] rtd; logic [31:0] imm; logic ui; logic [4:0] sh; logic [4:0] wa;
    logic we; logic mr; logic mw; logic fl;
  } id_t;

  typedef struct packed {
    logic [4:0] ma; logic mwe; logic [31:0] md; logic [4:0] wa; logic wwe; logic [31:0] wd;
  } fw_t;

  typedef struct packed {
    logic v; logic [4:0] op; logic [31:0] s0; logic [31:0] s1; logic [31:0] sd;
    logic [4:0] wa; logic we; logic mr; logic mw; logic [4:0] sh;
  } ex_t;

  typedef struct packed {
    id_t id; fw_t fw; logic st; ex_t ex;
  } vec_t;

  localparam int N = 18;
  vec_t tbl [N];
  ex_t  exp_q [$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_ex(input int idx, input ex_t e);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".valid"}, 32'(bus.ex_valid_o), 32'(e.v));
    chk({p, ".aluop"}, 32'(bus.ex_aluop_o), 32'(e.op));
    chk({p, ".src0"}, bus.ex_src0_o, e.s0);
    chk({p, ".src1"}, bus.ex_src1_o, e.s1);
    chk({p, ".store"}, bus.ex_store_data_o, e.sd);
    chk({p, ".wb_addr"}, 32'(bus.ex_wb_addr_o), 32'(e.wa));
    chk({p, ".wb_we"}, 32'(bus.ex_wb_we_o), 32'(e.we));
    chk({p, ".mem_rd"}, 32'(bus.ex_mem_rd_o), 32'(e.mr));
    chk({p, ".mem_wr"}, 32'(bus.ex_mem_wr_o), 32'(e.mw));
    chk({p, ".shamt"}, 32'(bus.ex_shamt_o), 32'(e.sh));
  endtask

  task automatic drive_id(input id_t i);
    bus.id_valid_i   = i.iv;  bus.id_aluop_i   = i.op;
    bus.id_rs_addr_i = i.rs;  bus.id_rs_data_i = i.rsd;
    bus.id_rt_addr_i = i.rt;  bus.id_rt_data_i = i.rtd;
    bus.id_imm_i     = i.imm; bus.id_use_imm_i = i.ui;
    bus.id_shamt_i   = i.sh;  bus.id_wb_addr_i = i.wa;
    bus.id_wb_we_i   = i.we;  bus.id_mem_rd_i  = i.mr;
    bus.id_mem_wr_i  = i.mw;  bus.flush_i      = i.fl;
  endtask

  task automatic drive_fw(input fw_t f);
    bus.mem_wb_addr_i = f.ma; bus.mem_we_i = f.mwe; bus.mem_data_i = f.md;
    bus.wb_addr_i     = f.wa; bus.wb_we_i  = f.wwe; bus.wb_data_i  = f.wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    id_t IDLE;
    fw_t NOFW;
    ex_t BUB;
    ex_t e;
    IDLE = '0;
    NOFW = '0;
    BUB  = '{0, 5'h1F, 0, 0, 0, 0, 0, 0, 0, 0};

    // id: iv op rs rsd rt rtd imm ui sh wa we mr mw fl | ex: v op s0 s1 sd wa we mr mw sh
    // add r3,r1,r2
    tbl[0]  = '{'{1, 0, 1, 32'h11, 2, 32'h22, 0, 0, 0, 3, 1, 0, 0, 0}, NOFW, 0,
                '{1, 0, 32'h11, 32'h22, 32'h22, 3, 1, 0, 0, 0}};
    // sub r4,r3,r1: r3 from EX/MEM
    tbl[1]  = '{'{1, 1, 3, 32'h0, 1, 32'h11, 0, 0, 0, 4, 1, 0, 0, 0},
                '{3, 1, 32'h10, 0, 0, 0}, 0, '{1, 1, 32'h10, 32'h11, 32'h11, 4, 1, 0, 0, 0}};
    // or r7,r3,r9: MEM beats WB on r3
    tbl[2]  = '{'{1, 2, 3, 32'h1, 9, 32'h99, 0, 0, 0, 7, 1, 0, 0, 0},
                '{3, 1, 32'hAAAA0000, 3, 1, 32'h5555}, 0,
                '{1, 2, 32'hAAAA0000, 32'h99, 32'h99, 7, 1, 0, 0, 0}};
    // and r8,r2,r4 shamt 7: rt from WB, non-matching MEM write
    tbl[3]  = '{'{1, 3, 2, 32'h22, 4, 32'h0, 0, 0, 7, 8, 1, 0, 0, 0},
                '{7, 1, 32'h77, 4, 1, 32'h44}, 0, '{1, 3, 32'h22, 32'h44, 32'h44, 8, 1, 0, 0, 7}};
    // addi r1,r0,5: r0 never forwarded
    tbl[4]  = '{'{1, 4, 0, 32'h0, 1, 32'hDEAD, 32'h5, 1, 0, 1, 1, 0, 0, 0},
                '{0, 1, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF}, 0,
                '{1, 4, 32'h0, 32'h5, 32'hDEAD, 1, 1, 0, 0, 0}};
    // lw r5,8(r1)
    tbl[5]  = '{'{1, 0, 1, 32'h100, 5, 32'h0, 32'h8, 1, 0, 5, 1, 1, 0, 0},
                '{1, 1, 32'h5, 0, 0, 0}, 0, '{1, 0, 32'h5, 32'h8, 32'h0, 5, 1, 1, 0, 0}};
    // add r6,r5,r0: load-use stall, bubble ignores forwarding
    tbl[6]  = '{'{1, 0, 5, 32'h0, 0, 32'h0, 0, 0, 0, 6, 1, 0, 0, 0},
                '{5, 1, 32'h1234, 0, 0, 0}, 1, BUB};
    tbl[7]  = '{'{1, 0, 5, 32'h0, 0, 32'h0, 0, 0, 0, 6, 1, 0, 0, 0},
                '{0, 0, 0, 5, 1, 32'hCAFE0005}, 0, '{1, 0, 32'hCAFE0005, 0, 0, 6, 1, 0, 0, 0}};
    // lw r9,0(r2) then sw r9 with flush: flush wins
    tbl[8]  = '{'{1, 0, 2, 32'h22, 9, 32'h0, 0, 1, 0, 9, 1, 1, 0, 0}, NOFW, 0,
                '{1, 0, 32'h22, 0, 0, 9, 1, 1, 0, 0}};
    tbl[9]  = '{'{1, 0, 3, 32'h3, 9, 32'h0, 32'h4, 1, 0, 0, 0, 0, 1, 1}, NOFW, 0, BUB};
    // lw r9 then sw r9,4(r3): store data hazard on rt despite use_imm
    tbl[10] = '{'{1, 0, 2, 32'h22, 9, 32'h0, 0, 1, 0, 9, 1, 1, 0, 0}, NOFW, 0,
                '{1, 0, 32'h22, 0, 0, 9, 1, 1, 0, 0}};
    tbl[11] = '{'{1, 0, 3, 32'h3, 9, 32'h0, 32'h4, 1, 0, 0, 0, 0, 1, 0}, NOFW, 1, BUB};
    tbl[12] = '{'{1, 0, 3, 32'h3, 9, 32'h0, 32'h4, 1, 0, 0, 0, 0, 1, 0},
                '{0, 0, 0, 9, 1, 32'h99990000}, 0,
                '{1, 0, 32'h3, 32'h4, 32'h99990000, 0, 0, 0, 1, 0}};
    // lw r10 then ori r10,r2,0xF: rt is a destination only, no stall
    tbl[13] = '{'{1, 0, 0, 32'h0, 10, 32'h0, 0, 1, 0, 10, 1, 1, 0, 0}, NOFW, 0,
                '{1, 0, 0, 0, 0, 10, 1, 1, 0, 0}};
    tbl[14] = '{'{1, 2, 2, 32'h22, 10, 32'h0, 32'hF, 1, 0, 10, 1, 0, 0, 0},
                '{0, 0, 0, 10, 1, 32'hAB}, 0, '{1, 2, 32'h22, 32'hF, 32'hAB, 10, 1, 0, 0, 0}};
    tbl[15] = '{'{0, 1, 10, 32'h5, 10, 32'h5, 0, 0, 0, 3, 1, 0, 0, 0}, NOFW, 0, BUB};
    // lw r11 then an invalid ID slot naming r11: no stall
    tbl[16] = '{'{1, 0, 0, 32'h0, 11, 32'h0, 0, 1, 0, 11, 1, 1, 0, 0}, NOFW, 0,
                '{1, 0, 0, 0, 0, 11, 1, 1, 0, 0}};
    tbl[17] = '{'{0, 0, 11, 32'h0, 11, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0}, NOFW, 0, BUB};

    rst_n = 1'b0;
    drive_id(IDLE);
    drive_fw(NOFW);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stall", 32'(bus.stall_o), 0);
    chk_ex(-1, BUB);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k <= N; k++) begin
      @(posedge clk);
      #1;
      if (k < N) drive_id(tbl[k].id); else drive_id(IDLE);
      if (k > 0) drive_fw(tbl[k-1].fw); else drive_fw(NOFW);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_ex(k - 1, e);
      end
      if (k < N) begin
        chk($sformatf("v%0d.stall", k), 32'(bus.stall_o), 32'(tbl[k].st));
        exp_q.push_back(tbl[k].ex);
      end
    end
    chk("queue_drained", 32'(exp_q.size()), 0);

    // Reset in the middle of a load-use stall
    @(posedge clk);
    #1;
    drive_id('{1, 0, 1, 32'h100, 5, 32'h0, 32'h8, 1, 0, 5, 1, 1, 0, 0});
    drive_fw(NOFW);
    @(posedge clk);
    #1;
    drive_id('{1, 0, 5, 32'h66, 0, 32'h0, 0, 0, 0, 6, 1, 0, 0, 0});
    #1;
    chk("rst.pre_stall", 32'(bus.stall_o), 1);
    chk("rst.pre_mem_rd", 32'(bus.ex_mem_rd_o), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.stall", 32'(bus.stall_o), 0);
    chk_ex(100, BUB);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.release_stall", 32'(bus.stall_o), 0);
    @(posedge clk);
    #1;
    drive_id(IDLE);
    #1;
    chk_ex(101, '{1, 0, 32'h66, 32'h0, 32'h0, 6, 1, 0, 0, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
